// File: rtl/cp0.sv
// System coprocessor 0 for the single-cycle MIPS CPU: EPC/Status/Cause registers,
// MFC0/MTC0/ERET decode, three-source exception arbitration and next-PC override.
module cp0 #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Inst,
    input  logic        ExpSrc0,
    input  logic        ExpSrc1,
    input  logic        ExpSrc2,
    input  logic        enable,
    input  logic [31:0] PCin,
    input  logic [31:0] Din,
    output logic        ExRegWrite,
    output logic        IsEret,
    output logic        ExpBlock,
    output logic        HasExp,
    output logic [31:0] PCout,
    output logic [31:0] Dout
);

    localparam logic [1:0] SEL_EPC    = 2'b00;
    localparam logic [1:0] SEL_STATUS = 2'b01;
    localparam logic [1:0] SEL_CAUSE  = 2'b10;

    logic        cop0;
    logic        mfc0;
    logic        mtc0;
    logic        eret;
    logic [1:0]  sel;

    // Only the architecturally live bits are stored; the rest always read as zero.
    logic [31:0] epc;
    logic [3:0]  status;
    logic [4:0]  cause;

    logic [2:0]  req;
    logic [1:0]  req_idx;
    logic        has_exp;

    assign cop0 = (Inst[31:26] == 6'b010000);
    assign mfc0 = cop0 && (Inst[25:21] == 5'b00000);
    assign mtc0 = cop0 && (Inst[25:21] == 5'b00100);
    assign eret = cop0 && (Inst[5:0] == 6'b011000);
    assign sel  = Inst[12:11];

    assign req     = {ExpSrc2, ExpSrc1, ExpSrc0} & status[2:0];
    assign has_exp = (|req) && !status[3];

    always_comb begin
        req_idx = 2'd0;
        if (req[0])
            req_idx = 2'd0;
        else if (req[1])
            req_idx = 2'd1;
        else if (req[2])
            req_idx = 2'd2;
    end

    assign ExRegWrite = mfc0;
    assign IsEret     = eret;
    assign ExpBlock   = status[3];
    assign HasExp     = has_exp;

    always_comb begin
        PCout = PCin;
        if (has_exp)
            PCout = HANDLER_ADDR;
        else if (eret)
            PCout = epc;
    end

    always_comb begin
        Dout = 32'd0;
        case (sel)
            SEL_EPC:    Dout = epc;
            SEL_STATUS: Dout = {28'd0, status};
            SEL_CAUSE:  Dout = {27'd0, cause};
            default:    Dout = 32'd0;
        endcase
    end

    // An exception takes precedence over ERET, which takes precedence over MTC0.
    always_ff @(posedge clk) begin
        if (rst) begin
            epc    <= 32'd0;
            status <= 4'h7;
            cause  <= 5'd0;
        end else if (has_exp) begin
            epc       <= PCin;
            status[3] <= 1'b1;
            cause     <= {req_idx, req};
        end else if (eret) begin
            status[3] <= 1'b0;
        end else if (mtc0 && enable) begin
            case (sel)
                SEL_EPC:    epc    <= Din;
                SEL_STATUS: status <= Din[3:0];
                default:    ;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios followed by randomized traffic
// compared against an abstract model of the coprocessor registers.
module tb_cp0;

    logic        clk;
    logic        rst;
    logic [31:0] Inst;
    logic        ExpSrc0;
    logic        ExpSrc1;
    logic        ExpSrc2;
    logic        enable;
    logic [31:0] PCin;
    logic [31:0] Din;
    logic        ExRegWrite;
    logic        IsEret;
    logic        ExpBlock;
    logic        HasExp;
    logic [31:0] PCout;
    logic [31:0] Dout;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_epc;
    logic [2:0]  m_mask;
    logic        m_blk;
    logic [2:0]  m_cause_req;
    int          m_cause_src;

    cp0 dut (
        .clk        (clk),
        .rst        (rst),
        .Inst       (Inst),
        .ExpSrc0    (ExpSrc0),
        .ExpSrc1    (ExpSrc1),
        .ExpSrc2    (ExpSrc2),
        .enable     (enable),
        .PCin       (PCin),
        .Din        (Din),
        .ExRegWrite (ExRegWrite),
        .IsEret     (IsEret),
        .ExpBlock   (ExpBlock),
        .HasExp     (HasExp),
        .PCout      (PCout),
        .Dout       (Dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [31:0] inst, input logic [2:0] src,
                                 input logic en, input logic [31:0] pc, input logic [31:0] din);
        Inst    = inst;
        ExpSrc0 = src[0];
        ExpSrc1 = src[1];
        ExpSrc2 = src[2];
        enable  = en;
        PCin    = pc;
        Din     = din;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] s);
        case (s)
            2'd0:    return m_epc;
            2'd1:    return 32'(m_mask) + (m_blk ? 32'd8 : 32'd0);
            2'd2:    return 32'(m_cause_req) + 32'(m_cause_src * 8);
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        logic [31:0] inst;
        logic [2:0]  src;
        logic [2:0]  pending;
        logic        en;
        logic        do_rst;
        logic [31:0] pc;
        logic [31:0] din;
        logic        is_cop0;
        logic        is_mfc0;
        logic        is_mtc0;
        logic        is_eret;
        logic        take;
        logic [31:0] exp_pc;
        int          kind;
        int          first;

        rst = 1'b1;
        applyStimulus(32'd0, 3'b000, 1'b0, 32'd0, 32'd0);

        // 1. reset
        tick();
        rst = 1'b0;
        applyStimulus(32'd0, 3'b000, 1'b0, 32'h0040_0004, 32'd0);
        checkOutput("rst_hasexp", 32'(HasExp), 32'd0);
        checkOutput("rst_block", 32'(ExpBlock), 32'd0);
        checkOutput("rst_pcout", PCout, 32'h0040_0004);
        checkOutput("rst_regwrite", 32'(ExRegWrite), 32'd0);
        applyStimulus(32'h4000_0000, 3'b000, 1'b0, 32'h0040_0004, 32'd0);
        checkOutput("rst_epc", Dout, 32'd0);
        applyStimulus(32'h4000_0800, 3'b000, 1'b0, 32'h0040_0004, 32'd0);
        checkOutput("rst_status", Dout, 32'd7);
        applyStimulus(32'h4000_1000, 3'b000, 1'b0, 32'h0040_0004, 32'd0);
        checkOutput("rst_cause", Dout, 32'd0);

        // 2. exception taken
        applyStimulus(32'd0, 3'b010, 1'b0, 32'h0040_0000, 32'd0);
        checkOutput("exc_hasexp", 32'(HasExp), 32'd1);
        checkOutput("exc_pcout", PCout, 32'h0000_0800);
        tick();
        applyStimulus(32'h4000_0000, 3'b000, 1'b0, 32'h0040_0004, 32'd0);
        checkOutput("exc_block", 32'(ExpBlock), 32'd1);
        checkOutput("exc_epc", Dout, 32'h0040_0000);
        applyStimulus(32'h4000_1000, 3'b000, 1'b0, 32'h0040_0004, 32'd0);
        checkOutput("exc_cause", Dout, 32'h0000_000A);
        applyStimulus(32'd0, 3'b001, 1'b0, 32'h0040_0004, 32'd0);
        checkOutput("exc_blocked", 32'(HasExp), 32'd0);
        tick();

        // 3. MTC0 / MFC0
        applyStimulus(32'h4080_0000, 3'b000, 1'b1, 32'h0040_0008, 32'h1234_5678);
        tick();
        applyStimulus(32'h4000_0000, 3'b000, 1'b0, 32'h0040_000C, 32'd0);
        checkOutput("mfc0_regwrite", 32'(ExRegWrite), 32'd1);
        checkOutput("mfc0_epc", Dout, 32'h1234_5678);
        applyStimulus(32'h4080_0000, 3'b000, 1'b0, 32'h0040_0010, 32'hAAAA_5555);
        tick();
        applyStimulus(32'h4000_0000, 3'b000, 1'b0, 32'h0040_0014, 32'd0);
        checkOutput("mtc0_noen", Dout, 32'h1234_5678);

        // 4. ERET
        applyStimulus(32'h4200_0018, 3'b000, 1'b0, 32'h0040_0018, 32'd0);
        checkOutput("eret_flag", 32'(IsEret), 32'd1);
        checkOutput("eret_pcout", PCout, 32'h1234_5678);
        checkOutput("eret_regwrite", 32'(ExRegWrite), 32'd0);
        tick();
        applyStimulus(32'd0, 3'b000, 1'b0, 32'h0040_001C, 32'd0);
        checkOutput("eret_unblock", 32'(ExpBlock), 32'd0);

        // 5. masking
        applyStimulus(32'h4080_0800, 3'b000, 1'b1, 32'h0040_0020, 32'h0000_0006);
        tick();
        applyStimulus(32'd0, 3'b001, 1'b0, 32'h0040_0100, 32'd0);
        checkOutput("mask_src0", 32'(HasExp), 32'd0);
        applyStimulus(32'd0, 3'b100, 1'b0, 32'h0040_0100, 32'd0);
        checkOutput("mask_src2", 32'(HasExp), 32'd1);
        checkOutput("mask_pcout", PCout, 32'h0000_0800);
        tick();
        applyStimulus(32'h4000_1000, 3'b000, 1'b0, 32'h0040_0104, 32'd0);
        checkOutput("mask_cause", Dout, 32'h0000_0014);
        applyStimulus(32'h4000_0800, 3'b000, 1'b0, 32'h0040_0104, 32'd0);
        checkOutput("mask_status", Dout, 32'h0000_000E);
        applyStimulus(32'h4200_0018, 3'b000, 1'b0, 32'h0040_0104, 32'd0);
        tick();
        applyStimulus(32'h4080_0800, 3'b000, 1'b1, 32'h0040_0108, 32'h0000_0007);
        tick();

        // 6. exception beats a simultaneous MTC0
        applyStimulus(32'h4080_0000, 3'b001, 1'b1, 32'h0040_0200, 32'hDEAD_BEEF);
        checkOutput("simul_hasexp", 32'(HasExp), 32'd1);
        tick();
        applyStimulus(32'h4000_0000, 3'b000, 1'b0, 32'h0040_0204, 32'd0);
        checkOutput("simul_epc", Dout, 32'h0040_0200);
        checkOutput("simul_block", 32'(ExpBlock), 32'd1);
        applyStimulus(32'h4000_1000, 3'b000, 1'b0, 32'h0040_0204, 32'd0);
        checkOutput("simul_cause", Dout, 32'h0000_0001);

        // A request held through ERET is taken on the first unblocked cycle
        applyStimulus(32'h4200_0018, 3'b010, 1'b0, 32'h0040_0208, 32'd0);
        checkOutput("held_blocked", 32'(HasExp), 32'd0);
        checkOutput("held_eret_pc", PCout, 32'h0040_0200);
        tick();
        applyStimulus(32'd0, 3'b010, 1'b0, 32'h0040_0300, 32'd0);
        checkOutput("held_taken", 32'(HasExp), 32'd1);
        tick();

        // Randomized traffic against the abstract model, from a fresh reset
        rst = 1'b1;
        applyStimulus(32'd0, 3'b000, 1'b0, 32'd0, 32'd0);
        tick();
        rst = 1'b0;
        m_epc = 32'd0; m_mask = 3'b111; m_blk = 1'b0; m_cause_req = 3'd0; m_cause_src = 0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            kind = int'($urandom_range(0, 4));
            case (kind)
                0: inst = {6'h10, 5'h00, 21'($urandom)};
                1: inst = {6'h10, 5'h04, 21'($urandom)};
                2: inst = {6'h10, 5'h10, 15'($urandom), 6'h18};
                3: inst = {6'h10, 26'($urandom)};
                default: inst = $urandom;
            endcase
            src[0] = ($urandom_range(0, 3) == 0);
            src[1] = ($urandom_range(0, 3) == 0);
            src[2] = ($urandom_range(0, 3) == 0);
            en     = 1'($urandom);
            pc     = $urandom;
            din    = $urandom;
            do_rst = ($urandom_range(0, 79) == 0);

            rst = do_rst;
            applyStimulus(inst, src, en, pc, din);

            is_cop0 = (inst[31:26] == 6'b010000);
            is_mfc0 = is_cop0 && (inst[25:21] == 5'd0);
            is_mtc0 = is_cop0 && (inst[25:21] == 5'd4);
            is_eret = is_cop0 && (inst[5:0] == 6'd24);
            pending = src & m_mask;
            take    = (pending != 3'd0) && !m_blk;
            exp_pc  = take ? 32'h0000_0800 : (is_eret ? m_epc : pc);

            checkOutput("rnd_hasexp", 32'(HasExp), 32'(take));
            checkOutput("rnd_pcout", PCout, exp_pc);
            checkOutput("rnd_dout", Dout, model_read(inst[12:11]));
            checkOutput("rnd_block", 32'(ExpBlock), 32'(m_blk));
            checkOutput("rnd_regwrite", 32'(ExRegWrite), 32'(is_mfc0));
            checkOutput("rnd_iseret", 32'(IsEret), 32'(is_eret));

            tick();

            if (do_rst) begin
                m_epc = 32'd0; m_mask = 3'b111; m_blk = 1'b0;
                m_cause_req = 3'd0; m_cause_src = 0;
            end else if (take) begin
                first = -1;
                for (int i = 0; i < 3; i++)
                    if (pending[i] && first < 0) first = i;
                m_epc = pc; m_blk = 1'b1;
                m_cause_req = pending; m_cause_src = first;
            end else if (is_eret) begin
                m_blk = 1'b0;
            end else if (is_mtc0 && en) begin
                if (inst[12:11] == 2'd0) m_epc = din;
                else if (inst[12:11] == 2'd1) begin
                    m_mask = din[2:0];
                    m_blk  = din[3];
                end
            end
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0.md
Name: cp0

Overview:
System coprocessor 0 for the single-cycle MIPS CPU. It holds the EPC, Status and Cause registers and arbitrates three external exception/interrupt request lines. It decodes MFC0/MTC0/ERET from the current instruction and supplies the next-PC override: handler entry on an exception, EPC on ERET, pass-through otherwise. It sits beside the register file and the PC mux.

Parameters:
HANDLER_ADDR, 32'h0000_0800, exception handler entry address driven on PCout when an exception is taken.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
Inst  in  32  current instruction word.
ExpSrc0  in  1  exception request 0; highest priority in Cause encoding.
ExpSrc1  in  1  exception request 1.
ExpSrc2  in  1  exception request 2.
enable  in  1  write enable for MTC0 register writes.
PCin  in  32  next-sequential PC from the datapath.
Din  in  32  MTC0 write data (GPR rt value).
ExRegWrite  out  1  MFC0 decoded; the CPU writes Dout into GPR rt.
IsEret  out  1  ERET decoded.
ExpBlock  out  1  exception-level bit; exceptions are blocked while it is 1.
HasExp  out  1  an exception is taken this cycle.
PCout  out  32  next PC.
Dout  out  32  CP0 register read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Decode (combinational):
  - COP0 = (Inst[31:26] == 6'b010000).
  - MFC0 = COP0 & (Inst[25:21] == 5'b00000).
  - MTC0 = COP0 & (Inst[25:21] == 5'b00100).
  - ERET = COP0 & (Inst[5:0] == 6'b011000); Inst[25:21] is ignored for ERET.
  - ExRegWrite = MFC0. IsEret = ERET.
- Register select: sel = Inst[12:11].
  - 00 = EPC.
  - 01 = Status.
  - 10 = Cause, read-only.
  - 11 = unused; reads 0, writes are ignored.
- Status register:
  - Status[2:0] = per-source mask (1 = enabled) for ExpSrc2..0.
  - Status[3] = block bit; ExpBlock = Status[3].
  - Status[31:4] read 0.
- Cause register:
  - Cause[2:0] = masked request vector latched when an exception is taken.
  - Cause[4:3] = encoded source index: lowest-numbered active masked source wins.
  - Other bits read 0.
- Request detection: req[2:0] = {ExpSrc2, ExpSrc1, ExpSrc0} & Status[2:0].
- HasExp = (|req) & ~Status[3]. Purely combinational, same cycle.
- PCout priority:
  - HasExp -> HANDLER_ADDR.
  - else IsEret -> EPC.
  - else PCin.
- Dout: combinational read of the selected register. It shows the pre-edge value; there is no write-through bypass.
- Rising edge of clk, in priority order:
  1. rst: EPC = 0, Status = 32'h0000_0007, Cause = 0.
  2. HasExp:
     - EPC <= PCin.
     - Status[3] <= 1.
     - Cause[2:0] <= req; Cause[4:3] <= encoded index.
     - A simultaneous MTC0 or ERET is discarded.
  3. ERET (no exception this cycle): Status[3] <= 0. Other state is unchanged.
  4. MTC0 & enable:
     - Write Din to the selected register: EPC gets all 32 bits; Status gets bits [3:0] only.
     - Writes to Cause or sel 11 are ignored.
  - MTC0 with enable = 0: no state change.
- Blocking:
  - While Status[3] = 1, requests are ignored; they are not queued.
  - A request still asserted after ERET is taken on the first cycle after the block clears.
- Request lines are level-sensitive and sampled every cycle.

Test Plan:
1. Reset: rst = 1 for one edge.
   -> EPC = 0, Status = 7, Cause = 0, ExpBlock = 0, HasExp = 0.
   -> With Inst = 0 and PCin = 0x00400004, PCout = 0x00400004.
2. Exception taken: PCin = 0x00400000, ExpSrc1 = 1 for one cycle.
   -> During that cycle: HasExp = 1, PCout = 0x00000800.
   -> After the edge: ExpBlock = 1, EPC = 0x00400000, Cause = 0x0000000A.
   -> Asserting ExpSrc0 next cycle gives HasExp = 0.
3. MTC0 and MFC0:
   -> Inst = 0x40800000 (mtc0, sel 00), Din = 0x12345678, enable = 1 for one edge.
   -> Then Inst = 0x40000000 (mfc0, sel 00) -> ExRegWrite = 1, Dout = 0x12345678.
   -> Repeating the mtc0 with enable = 0 leaves EPC unchanged.
4. ERET: state from scenario 3, Inst = 0x42000018.
   -> IsEret = 1, PCout = 0x12345678.
   -> After the edge: ExpBlock = 0.
5. Masking: mtc0 to Status (Inst = 0x40800800) with Din = 0x00000006, then ExpSrc0 = 1.
   -> HasExp = 0.
   -> With ExpSrc2 = 1 instead: HasExp = 1, and Cause after the edge = 0x00000014.
6. Simultaneous events: ExpSrc0 = 1 together with Inst = mtc0 EPC, Din = 0xDEADBEEF, enable = 1.
   -> EPC = PCin (the MTC0 write is dropped); Status[3] = 1.
